// File: rtl/partial_phase_sweeper.sv
// Phase accumulator bank: sweeps every partial once per sample tick, streaming
// pre-increment phases and writing back the advanced phase; host config is taken only when idle.
module partial_phase_sweeper #(
    parameter int unsigned PHASE_WIDTH  = 24,
    parameter int unsigned NUM_PARTIALS = 64,
    localparam int unsigned IW = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_addr,
    input  logic [PHASE_WIDTH-1:0] cfg_incr,
    input  logic                   cfg_zero_phase,
    output logic                   cfg_ready,
    output logic                   busy,
    output logic                   phase_valid,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [IW-1:0]          partial_idx,
    output logic                   phase_last,
    output logic                   overrun
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PARTIALS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t state, state_next;
    logic [IW-1:0] idx, idx_next;

    logic [PHASE_WIDTH-1:0] incr_ram  [NUM_PARTIALS];
    logic [PHASE_WIDTH-1:0] phase_ram [NUM_PARTIALS];

    logic                   incr_we, phase_we;
    logic [IW-1:0]          wr_addr;
    logic [PHASE_WIDTH-1:0] incr_wdata, phase_wdata;

    logic                   valid_next, last_next, overrun_next;
    logic [PHASE_WIDTH-1:0] phase_next;
    logic [IW-1:0]          pidx_next;

    // Next-state, RAM write port and output next-values
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        incr_we      = 1'b0;
        phase_we     = 1'b0;
        wr_addr      = idx;
        incr_wdata   = '0;
        phase_wdata  = '0;
        valid_next   = 1'b0;
        last_next    = 1'b0;
        overrun_next = 1'b0;
        phase_next   = phase_out;
        pidx_next    = partial_idx;

        case (state)
            ST_CLEAR: begin
                incr_we      = 1'b1;
                phase_we     = 1'b1;
                overrun_next = sample_tick;
                if (idx == LAST_IDX) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            ST_IDLE: begin
                if (cfg_we) begin
                    wr_addr    = cfg_addr;
                    incr_we    = 1'b1;
                    incr_wdata = cfg_incr;
                    phase_we   = cfg_zero_phase;
                end
                if (sample_tick) begin
                    state_next = ST_SWEEP;
                    idx_next   = '0;
                end
            end
            ST_SWEEP: begin
                phase_we     = 1'b1;
                phase_wdata  = phase_ram[idx] + incr_ram[idx];
                valid_next   = 1'b1;
                last_next    = (idx == LAST_IDX);
                phase_next   = phase_ram[idx];
                pidx_next    = idx;
                overrun_next = sample_tick;
                if (idx == LAST_IDX) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IW'(1);
                end
            end
            default: begin
                state_next = ST_CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            idx         <= '0;
            busy        <= 1'b1;
            cfg_ready   <= 1'b0;
            phase_valid <= 1'b0;
            phase_last  <= 1'b0;
            overrun     <= 1'b0;
            phase_out   <= '0;
            partial_idx <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            busy        <= (state_next != ST_IDLE);
            cfg_ready   <= (state_next == ST_IDLE);
            phase_valid <= valid_next;
            phase_last  <= last_next;
            overrun     <= overrun_next;
            phase_out   <= phase_next;
            partial_idx <= pidx_next;
        end
    end

    // Distributed RAMs; contents are re-zeroed by the CLEAR walk rather than by reset
    always_ff @(posedge clk) begin
        if (incr_we) begin
            incr_ram[wr_addr] <= incr_wdata;
        end
        if (phase_we) begin
            phase_ram[wr_addr] <= phase_wdata;
        end
    end

endmodule

// File: tb/tb_partial_phase_sweeper.sv
// Directed bench for partial_phase_sweeper with a cycle-indexed expectation model
// and a per-cycle compare process on the falling edge.
module tb_partial_phase_sweeper;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_tick;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [W-1:0]  cfg_incr;
    logic          cfg_zero_phase;
    logic          cfg_ready;
    logic          busy;
    logic          phase_valid;
    logic [W-1:0]  phase_out;
    logic [IW-1:0] partial_idx;
    logic          phase_last;
    logic          overrun;

    always #5 clk = ~clk;

    partial_phase_sweeper #(.PHASE_WIDTH(W), .NUM_PARTIALS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_tick    (sample_tick),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_incr       (cfg_incr),
        .cfg_zero_phase (cfg_zero_phase),
        .cfg_ready      (cfg_ready),
        .busy           (busy),
        .phase_valid    (phase_valid),
        .phase_out      (phase_out),
        .partial_idx    (partial_idx),
        .phase_last     (phase_last),
        .overrun        (overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  ph;
        logic          last;
    } exp_t;

    // Model state: per-partial increments/phases plus per-cycle expectations
    logic [W-1:0] incr_m  [N];
    logic [W-1:0] phase_m [N];
    exp_t exp_out  [int];
    bit   exp_busy [int];
    bit   exp_ovr  [int];
    bit   checking = 1'b0;

    logic [W-1:0] cap [N];
    int valid_count = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("phase_valid", 32'(phase_valid), 32'(exp_out.exists(cyc)));
            if (exp_out.exists(cyc)) begin
                chk("phase_out", 32'(phase_out), 32'(exp_out[cyc].ph));
                chk("partial_idx", 32'(partial_idx), 32'(exp_out[cyc].idx));
                chk("phase_last", 32'(phase_last), 32'(exp_out[cyc].last));
                cap[exp_out[cyc].idx] = phase_out;
                valid_count++;
            end else begin
                chk("phase_last_idle", 32'(phase_last), 32'(0));
            end
            chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
            chk("cfg_ready", 32'(cfg_ready), 32'(!exp_busy.exists(cyc)));
            chk("overrun", 32'(overrun), 32'(exp_ovr.exists(cyc)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void purge_after(input int r);
        int ko[$];
        int kb[$];
        int kv[$];
        foreach (exp_out[k])  if (k > r) ko.push_back(k);
        foreach (exp_busy[k]) if (k > r) kb.push_back(k);
        foreach (exp_ovr[k])  if (k > r) kv.push_back(k);
        foreach (ko[i]) exp_out.delete(ko[i]);
        foreach (kb[i]) exp_busy.delete(kb[i]);
        foreach (kv[i]) exp_ovr.delete(kv[i]);
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            purge_after(cyc);
            for (int i = 1; i <= int'(N); i++) exp_busy[cyc + i] = 1'b1;
            for (int p = 0; p < int'(N); p++) begin
                incr_m[p]  = '0;
                phase_m[p] = '0;
            end
            step();
        end
        rst = 1'b0;
    endtask

    // One cycle of host activity: optional tick and/or config write
    task automatic drive(input bit tk, input bit we, input int a, input int v, input bit z);
        int t;
        t = cyc;
        sample_tick    = tk;
        cfg_we         = we;
        cfg_addr       = IW'(a);
        cfg_incr       = W'(v);
        cfg_zero_phase = z;
        if (!exp_busy.exists(t)) begin
            if (we) begin
                incr_m[a] = W'(v);
                if (z) phase_m[a] = '0;
            end
            if (tk) begin
                for (int i = 0; i < int'(N); i++) begin
                    exp_out[t + 2 + i] = '{idx: IW'(i), ph: phase_m[i], last: (i == int'(N) - 1)};
                    phase_m[i] = phase_m[i] + incr_m[i];
                    exp_busy[t + 1 + i] = 1'b1;
                end
            end
        end else if (tk) begin
            exp_ovr[t + 1] = 1'b1;
        end
        step();
        sample_tick    = 1'b0;
        cfg_we         = 1'b0;
        cfg_zero_phase = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_busy.exists(cyc) && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic check_sweep(input string name, input int e0, input int e1, input int e2, input int e3);
        chk({name, "_p0"}, 32'(cap[0]), 32'(e0));
        chk({name, "_p1"}, 32'(cap[1]), 32'(e1));
        chk({name, "_p2"}, 32'(cap[2]), 32'(e2));
        chk({name, "_p3"}, 32'(cap[3]), 32'(e3));
    endtask

    task automatic sweep_and_check(input string name, input int e0, input int e1, input int e2, input int e3);
        int vc0;
        vc0 = valid_count;
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        repeat (5) step();
        chk({name, "_count"}, 32'(valid_count - vc0), 32'(N));
        check_sweep(name, e0, e1, e2, e3);
    endtask

    initial begin
        int vc0;
        rst = 1'b1;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_incr = '0;
        cfg_zero_phase = 1'b0;
        foreach (cap[i]) cap[i] = 'x;

        do_reset(3);
        checking = 1'b1;
        wait_idle();

        // 1-cycle reset pulse from IDLE, then an all-zero sweep
        do_reset(1);
        chk("rst_phase_out", 32'(phase_out), 32'(0));
        chk("rst_partial_idx", 32'(partial_idx), 32'(0));
        wait_idle();
        sweep_and_check("clear", 0, 0, 0, 0);

        // Accumulate with wrap at 255
        drive(1'b0, 1'b1, 0, 1, 1'b0);
        drive(1'b0, 1'b1, 1, 2, 1'b0);
        drive(1'b0, 1'b1, 2, 3, 1'b0);
        drive(1'b0, 1'b1, 3, 255, 1'b0);
        sweep_and_check("acc0", 0, 0, 0, 0);
        sweep_and_check("acc1", 1, 2, 3, 255);
        sweep_and_check("acc2", 2, 4, 6, 254);

        // Zero partial 2's phase while rewriting its increment
        drive(1'b0, 1'b1, 2, 3, 1'b1);
        sweep_and_check("zero", 3, 6, 0, 253);

        // Second tick two cycles in is dropped
        vc0 = valid_count;
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        step();
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        repeat (4) step();
        chk("ovr_count", 32'(valid_count - vc0), 32'(N));
        check_sweep("ovr", 4, 8, 3, 252);
        sweep_and_check("post_ovr", 5, 10, 6, 251);

        // Config write coincident with the tick is used by that sweep
        vc0 = valid_count;
        drive(1'b1, 1'b1, 0, 10, 1'b0);
        repeat (5) step();
        check_sweep("simul", 6, 12, 9, 250);
        sweep_and_check("after_simul", 16, 14, 12, 249);

        // Reset two cycles into a sweep
        drive(1'b1, 1'b0, 0, 0, 1'b0);
        step();
        do_reset(1);
        chk("midrst_phase_out", 32'(phase_out), 32'(0));
        chk("midrst_phase_valid", 32'(phase_valid), 32'(0));
        wait_idle();
        sweep_and_check("midrst", 0, 0, 0, 0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
